init_seq: RTL and testbench



---
 rtl/init_seq_pkg.sv | 29 ++
 rtl/init_seq_sync_edge.sv | 36 +++
 rtl/init_seq.sv | 201 ++++++++++++++++++++
 tb/tb_init_seq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/init_seq_pkg.sv
// init_seq_pkg: shared types and defaults for the init_seq sequencer.
// Holds the FSM state enum, index-width helper and timing defaults.
package init_seq_pkg;

  localparam int DEF_NUM_UART      = 2;
  localparam int DEF_BAUD_W        = 16;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_BAUD_ST       = 100;
  localparam int DEF_NUM_ADC_PULSE = 2;
  localparam int DEF_ADC_PULSE_LEN = 1;
  localparam int DEF_ADC_GAP       = 20;
  localparam int DEF_WAIT_LEN      = 50;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BAUD,
    S_ADC_HI,
    S_ADC_LO,
    S_SETTLE,
    S_DONE
  } state_e;

  // Index width for a count of n items; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/init_seq_sync_edge.sv
// sync_edge: two-flop synchroniser plus rising-edge detector.
// Ports: clk, rst (sync, active-high), d (async in), q_s (synced), rise.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q_s,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic dly_q, dly_d;

  always_comb begin
    s1_d  = d;
    s2_d  = s1_q;
    dly_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      dly_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      dly_q <= dly_d;
    end
  end

  assign q_s  = s2_q;
  assign rise = s2_q & ~dly_q;

endmodule

// File: rtl/init_seq.sv
// init_seq: power-up sequencer; waits after PLL lock, strobes UART baud
// latches in turn, pulses ADC init, settles and holds done.
// Ports: clk, rst (sync active-high), locked (async), restart (1-cycle),
//   baud_cfg (per-channel words in), latch_baud (one-hot strobe),
//   baud_word (captured cfg), init_adc, busy, done, lock_loss_cnt.
// Build option: define INIT_SEQ_LOSS_CNT_EN to enable the saturating
//   lock_loss_cnt; otherwise the port is tied to zero.
module init_seq
  import init_seq_pkg::*;
#(
  parameter int NUM_UART      = DEF_NUM_UART,
  parameter int BAUD_W        = DEF_BAUD_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int BAUD_ST       = DEF_BAUD_ST,
  parameter int NUM_ADC_PULSE = DEF_NUM_ADC_PULSE,
  parameter int ADC_PULSE_LEN = DEF_ADC_PULSE_LEN,
  parameter int ADC_GAP       = DEF_ADC_GAP,
  parameter int WAIT_LEN      = DEF_WAIT_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       locked,
  input  logic                       restart,
  input  logic [NUM_UART*BAUD_W-1:0] baud_cfg,
  output logic [NUM_UART-1:0]        latch_baud,
  output logic [NUM_UART*BAUD_W-1:0] baud_word,
  output logic                       init_adc,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 lock_loss_cnt
);

  localparam int CH_W = idx_w(NUM_UART);
  localparam int P_W  = idx_w(NUM_ADC_PULSE);

  localparam logic [CNT_W-1:0] BAUD_END = CNT_W'(BAUD_ST - 1);
  localparam logic [CNT_W-1:0] HI_END   = CNT_W'(ADC_PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] LO_END   = CNT_W'(ADC_GAP - 1);
  localparam logic [CNT_W-1:0] SET_END  = CNT_W'(WAIT_LEN - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_UART - 1);
  localparam logic [P_W-1:0]   P_LAST   = P_W'(NUM_ADC_PULSE - 1);

  logic locked_s;
  logic rise;
  logic lost;
  logic clr;

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [P_W-1:0]   p_q, p_d;

  logic [NUM_UART-1:0]        latch_q, latch_d;
  logic [NUM_UART*BAUD_W-1:0] bw_q, bw_d;
  logic                       adc_q, adc_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  sync_edge u_lock_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (locked),
    .q_s  (locked_s),
    .rise (rise)
  );

  assign lost = (state_q != S_IDLE) && !locked_s;

  // Next state; lock loss beats restart, which beats normal progress.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    p_d     = p_q;
    clr     = 1'b0;
    if (lost) begin
      state_d = S_IDLE;
    end else if (restart && locked_s) begin
      state_d = S_WAIT;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rise) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == BAUD_END) begin
            state_d = S_BAUD;
            ch_d    = '0;
          end
        end
        S_BAUD: begin
          if (ch_q == CH_LAST) begin
            state_d = S_ADC_HI;
            p_d     = '0;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
        S_ADC_HI: begin
          if (cnt_q == HI_END) state_d = S_ADC_LO;
        end
        S_ADC_LO: begin
          if (cnt_q == LO_END) begin
            if (p_q == P_LAST) begin
              state_d = S_SETTLE;
            end else begin
              p_d     = p_q + P_W'(1);
              state_d = S_ADC_HI;
            end
          end
        end
        S_SETTLE: begin
          if (cnt_q == SET_END) state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    // Counter restarts on every state change and idles in IDLE/DONE.
    if (clr || (state_d != state_q) ||
        (state_d == S_IDLE) || (state_d == S_DONE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Registered outputs decoded from the next state.
  always_comb begin
    latch_d = '0;
    for (int i = 0; i < NUM_UART; i++) begin
      latch_d[i] = (state_d == S_BAUD) && (ch_d == CH_W'(i));
    end
    // Snapshot lands in the last WAIT cycle, one ahead of the strobes.
    bw_d = bw_q;
    if ((state_d == S_WAIT) && (cnt_d == BAUD_END)) begin
      bw_d = baud_cfg;
    end
    adc_d  = (state_d == S_ADC_HI);
    busy_d = !((state_d == S_IDLE) || (state_d == S_DONE));
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      p_q     <= '0;
      latch_q <= '0;
      bw_q    <= '0;
      adc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      p_q     <= p_d;
      latch_q <= latch_d;
      bw_q    <= bw_d;
      adc_q   <= adc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign latch_baud = latch_q;
  assign baud_word  = bw_q;
  assign init_adc   = adc_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef INIT_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (lost && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_q <= 8'd0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_init_seq.sv
// tb_init_seq: self-checking bench for init_seq (default and wide configs).
// Directed timing table plus randomized lock/restart against a model.
module tb_init_seq;

  localparam int BST = 100;
  localparam int GAP = 20;
  localparam int WL  = 50;

  logic        clk;
  logic        rst;
  logic        locked;
  logic        restart;
  logic [31:0] cfg_a;
  logic [63:0] cfg_b;

  logic [1:0]  lb_a;
  logic [31:0] bwo_a;
  logic        adc_a, busy_a, done_a;
  logic [7:0]  loss_a;
  logic [3:0]  lb_b;
  logic [63:0] bwo_b;
  logic        adc_b, busy_b, done_b;
  logic [7:0]  loss_b;

  init_seq u_a (
    .clk           (clk),
    .rst           (rst),
    .locked        (locked),
    .restart       (restart),
    .baud_cfg      (cfg_a),
    .latch_baud    (lb_a),
    .baud_word     (bwo_a),
    .init_adc      (adc_a),
    .busy          (busy_a),
    .done          (done_a),
    .lock_loss_cnt (loss_a)
  );

  init_seq #(
    .NUM_UART      (4),
    .NUM_ADC_PULSE (3),
    .ADC_PULSE_LEN (2)
  ) u_b (
    .clk           (clk),
    .rst           (rst),
    .locked        (locked),
    .restart       (restart),
    .baud_cfg      (cfg_b),
    .latch_baud    (lb_b),
    .baud_word     (bwo_b),
    .init_adc      (adc_b),
    .busy          (busy_b),
    .done          (done_b),
    .lock_loss_cnt (loss_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: sequence start edge, sync pipeline, loss count.
  int          e       = 0;
  int          m_start = 0;
  bit          m_act   = 0;
  bit          m_s1    = 0;
  bit          m_s     = 0;
  bit          m_d     = 0;
  int          m_loss  = 0;
  logic [31:0] mbw_a   = '0;
  logic [63:0] mbw_b   = '0;

  typedef struct {
    int         off;
    logic [1:0] lb;
    logic       adc;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)",
                 nm, act, want, $time);
    end
  endtask

  // Outputs k cycles after WAIT entry, from the schedule arithmetic.
  function automatic void exp_out(input int k, input int nu, input int np,
                                  input int pl, output logic [3:0] lb,
                                  output logic adc, output logic bsy,
                                  output logic dn);
    int base;
    int endk;
    base = BST + nu;
    endk = base + np * (pl + GAP);
    lb   = '0;
    adc  = 1'b0;
    if (k >= BST && k < base) lb[k - BST] = 1'b1;
    if (k >= base && k < endk && ((k - base) % (pl + GAP)) < pl)
      adc = 1'b1;
    bsy = (k < endk + WL);
    dn  = !bsy;
  endfunction

  function automatic int exp_loss();
`ifdef INIT_SEQ_LOSS_CNT_EN
    return m_loss;
`else
    return 0;
`endif
  endfunction

  task automatic model_edge();
    bit ls;
    bit rs;
    e++;
    if (rst) begin
      m_act  = 0;
      m_s1   = 0;
      m_s    = 0;
      m_d    = 0;
      m_loss = 0;
      mbw_a  = '0;
      mbw_b  = '0;
    end else begin
      ls = m_s;
      rs = m_s && !m_d;
      if (m_act && !ls) begin
        m_act = 0;
        if (m_loss < 255) m_loss++;
      end else if (restart && ls) begin
        m_act   = 1;
        m_start = e;
      end else if (!m_act && rs) begin
        m_act   = 1;
        m_start = e;
      end
      if (m_act && (e - m_start) == BST - 1) begin
        mbw_a = cfg_a;
        mbw_b = cfg_b;
      end
      m_d  = m_s;
      m_s  = m_s1;
      m_s1 = locked;
    end
  endtask

  task automatic check_all();
    logic [3:0] lb;
    logic       adc, bsy, dn;
    lb = '0; adc = 0; bsy = 0; dn = 0;
    if (m_act) exp_out(e - m_start, 2, 3 - 1, 1, lb, adc, bsy, dn);
    chk("a_ctl", {59'd0, lb_a, adc_a, busy_a, done_a},
        {59'd0, lb[1:0], adc, bsy, dn});
    chk("a_bw", {32'd0, bwo_a}, {32'd0, mbw_a});
    lb = '0; adc = 0; bsy = 0; dn = 0;
    if (m_act) exp_out(e - m_start, 4, 3, 2, lb, adc, bsy, dn);
    chk("b_ctl", {57'd0, lb_b, adc_b, busy_b, done_b},
        {57'd0, lb, adc, bsy, dn});
    chk("b_bw", bwo_b, mbw_b);
    chk("loss_a", {56'd0, loss_a}, 64'(exp_loss()));
    chk("loss_b", {56'd0, loss_b}, 64'(exp_loss()));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic reset_dut();
    rst     = 1'b1;
    locked  = 1'b0;
    restart = 1'b0;
    repeat (3) step();
    chk("rst_state", {46'd0, lb_a, adc_a, busy_a, done_a, loss_a, lb_b},
        64'd0);
    rst = 1'b0;
  endtask

  // Step until t0+upto, comparing against the fixed timing table.
  task automatic run_table(input int t0, input int upto);
    while (e < t0 + upto) begin
      step();
      for (int i = 0; i < 12; i++) begin
        if (e - t0 == tbl[i].off) begin
          chk("tbl_ctl", {59'd0, lb_a, adc_a, busy_a, done_a},
              {59'd0, tbl[i].lb, tbl[i].adc, tbl[i].busy, tbl[i].done});
          chk("tbl_bw", {32'd0, bwo_a}, {32'd0, 16'd5, 16'd2});
        end
      end
    end
  endtask

  initial begin
    int t0;
    int na, nb, nadc;
    int hold;

    tbl = '{
      '{ 99, 2'b00, 1'b0, 1'b1, 1'b0},
      '{100, 2'b01, 1'b0, 1'b1, 1'b0},
      '{101, 2'b10, 1'b0, 1'b1, 1'b0},
      '{102, 2'b00, 1'b1, 1'b1, 1'b0},
      '{103, 2'b00, 1'b0, 1'b1, 1'b0},
      '{122, 2'b00, 1'b0, 1'b1, 1'b0},
      '{123, 2'b00, 1'b1, 1'b1, 1'b0},
      '{124, 2'b00, 1'b0, 1'b1, 1'b0},
      '{143, 2'b00, 1'b0, 1'b1, 1'b0},
      '{193, 2'b00, 1'b0, 1'b1, 1'b0},
      '{194, 2'b00, 1'b0, 1'b0, 1'b1},
      '{199, 2'b00, 1'b0, 1'b0, 1'b1}
    };

    rst     = 1'b1;
    locked  = 1'b0;
    restart = 1'b0;
    cfg_a   = {16'd5, 16'd2};
    cfg_b   = 64'h0004_0003_0002_0001;

    // Clean start and default timing.
    reset_dut();
    locked = 1'b1;
    t0 = e + 3;
    run_table(t0, 200);

    // Lock loss during ADC_LO.
    reset_dut();
    locked = 1'b1;
    t0 = e + 3;
    while (e < t0 + 110) step();
    locked = 1'b0;
    repeat (3) step();
    chk("loss_idle", {61'd0, busy_a, done_a, adc_a}, 64'd0);
`ifdef INIT_SEQ_LOSS_CNT_EN
    chk("loss_cnt1", {56'd0, loss_a}, 64'd1);
`else
    chk("loss_cnt0", {56'd0, loss_a}, 64'd0);
`endif

    // Relock, reach DONE, then restart from DONE.
    locked = 1'b1;
    t0 = e + 3;
    while (e < t0 + 200) step();
    chk("done_hold", {62'd0, done_a, busy_a}, 64'd2);
    restart = 1'b1;
    step();
    restart = 1'b0;
    t0 = e;
    chk("restart_done", {62'd0, done_a, busy_a}, 64'd1);
    run_table(t0, 200);

    // Restart coinciding with the synchronised rise.
    reset_dut();
    locked = 1'b1;
    step();
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    na = 0; nb = 0; nadc = 0;
    repeat (240) begin
      step();
      na   += $countones(lb_a);
      nb   += $countones(lb_b);
      nadc += int'(adc_b);
    end
    chk("strobes_a", 64'(na), 64'd2);
    chk("strobes_b", 64'(nb), 64'd4);
    chk("adc_hi_b", 64'(nadc), 64'd6);

    // Repeated lock loss, saturation and reset clear.
    reset_dut();
    repeat (300) begin
      locked = 1'b1;
      repeat (4) step();
      locked = 1'b0;
      repeat (4) step();
    end
`ifdef INIT_SEQ_LOSS_CNT_EN
    chk("loss_sat", {56'd0, loss_a}, 64'd255);
`else
    chk("loss_sat", {56'd0, loss_a}, 64'd0);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("loss_clr", {48'd0, loss_a, loss_b}, 64'd0);

    // Randomized lock/restart/cfg/reset traffic.
    hold = 0;
    for (int i = 0; i < 15000; i++) begin
      if (hold == 0) begin
        locked = ~locked;
        hold   = $urandom_range(1, 400);
      end
      hold--;
      restart = ($urandom_range(0, 149) == 0);
      rst     = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 49) == 0) begin
        cfg_a = $urandom;
        cfg_b = {$urandom, $urandom};
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
